// File: rtl/bp_hb_mem_resp_gen.sv
// Gathers manycore return words per tag and streams them out as BedRock
// response beats. One response is assembled at a time; other tags wait.
module bp_hb_mem_resp_gen #(
   parameter int unsigned tag_width_p     = 4,
   parameter int unsigned hdr_width_p     = 64,
   parameter int unsigned fill_width_p    = 64,
   parameter int unsigned hb_data_width_p = 32,
   parameter int unsigned max_words_p     = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       hdr_v_i,
   output logic                       hdr_ready_o,
   input  logic [tag_width_p-1:0]     hdr_tag_i,
   input  logic [hdr_width_p-1:0]     hdr_i,
   input  logic [4:0]                 hdr_words_i,
   input  logic                       ret_v_i,
   output logic                       ret_ready_o,
   input  logic [tag_width_p-1:0]     ret_tag_i,
   input  logic [3:0]                 ret_word_i,
   input  logic [hb_data_width_p-1:0] ret_data_i,
   output logic [hdr_width_p-1:0]     mem_header_o,
   output logic [fill_width_p-1:0]    mem_data_o,
   output logic                       mem_v_o,
   output logic                       mem_last_o,
   input  logic                       mem_ready_and_i
);

   localparam int unsigned entries_lp = 1 << tag_width_p;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCollect = 2'd1;
   localparam logic [1:0] StStream  = 2'd2;

   logic [entries_lp-1:0]      valid_q;
   logic [hdr_width_p-1:0]     hdr_tab_q   [entries_lp];
   logic [4:0]                 words_tab_q [entries_lp];
   logic [hb_data_width_p-1:0] buf_q       [max_words_p];

   logic [1:0]             state_q, state_d;
   logic [tag_width_p-1:0] active_q;
   logic [4:0]             rcv_cnt_q;
   logic [3:0]             beat_q;

   logic                       hdr_fire, ret_fire, beat_fire, last_beat;
   logic [4:0]                 act_words, num_beats, lo_idx, hi_idx, rcv_inc;
   logic [hb_data_width_p-1:0] lo_word, hi_word;

   assign hdr_ready_o = ~valid_q[hdr_tag_i];
   assign hdr_fire    = hdr_v_i & hdr_ready_o;
   assign ret_fire    = ret_v_i & ret_ready_o;
   assign beat_fire   = mem_v_o & mem_ready_and_i;
   assign rcv_inc     = rcv_cnt_q + 5'd1;

   // A zero-word write ack still produces one (all-zero) beat.
   assign act_words = words_tab_q[active_q];
   assign num_beats = (act_words == 5'd0) ? 5'd1
                    : ({1'b0, act_words[4:1]} + {4'd0, act_words[0]});
   assign last_beat = ({1'b0, beat_q} == (num_beats - 5'd1));

   assign lo_idx  = {beat_q, 1'b0};
   assign hi_idx  = {beat_q, 1'b1};
   assign lo_word = (lo_idx < act_words) ? buf_q[lo_idx[3:0]] : '0;
   assign hi_word = (hi_idx < act_words) ? buf_q[hi_idx[3:0]] : '0;

   assign mem_v_o      = (state_q == StStream);
   assign mem_last_o   = mem_v_o & last_beat;
   assign mem_header_o = hdr_tab_q[active_q];
   assign mem_data_o   = {hi_word, lo_word};

   always_comb begin
      ret_ready_o = 1'b0;
      case (state_q)
         StIdle:    ret_ready_o = valid_q[ret_tag_i];
         StCollect: ret_ready_o = (ret_tag_i == active_q);
         default:   ret_ready_o = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (ret_fire) begin
               state_d = (words_tab_q[ret_tag_i] <= 5'd1) ? StStream : StCollect;
            end
         end
         StCollect: begin
            if (ret_fire && (rcv_inc == act_words)) state_d = StStream;
         end
         StStream: begin
            if (beat_fire && last_beat) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         valid_q   <= '0;
         active_q  <= '0;
         rcv_cnt_q <= '0;
         beat_q    <= '0;
      end else begin
         state_q <= state_d;
         if (hdr_fire) valid_q[hdr_tag_i] <= 1'b1;
         if (ret_fire) begin
            if (state_q == StIdle) begin
               active_q  <= ret_tag_i;
               rcv_cnt_q <= 5'd1;
            end else begin
               rcv_cnt_q <= rcv_inc;
            end
         end
         if (beat_fire) begin
            if (last_beat) begin
               valid_q[active_q] <= 1'b0;
               beat_q            <= '0;
            end else begin
               beat_q <= beat_q + 4'd1;
            end
         end
      end
   end

   // Buffer is cleared between responses so a short response never sees stale words.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < max_words_p; i++) buf_q[i] <= '0;
      end else if (ret_fire) begin
         buf_q[ret_word_i] <= ret_data_i;
      end else if (beat_fire && last_beat) begin
         for (int i = 0; i < max_words_p; i++) buf_q[i] <= '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (hdr_fire) begin
         hdr_tab_q[hdr_tag_i]   <= hdr_i;
         words_tab_q[hdr_tag_i] <= hdr_words_i;
      end
   end

endmodule

// File: tb/tb_bp_hb_mem_resp_gen.sv
// Bench for bp_hb_mem_resp_gen: fixed vectors, corner sequences and random
// responses checked against a word-array model of the expected beats.
module tb_bp_hb_mem_resp_gen;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        hdr_v_i = 1'b0;
   logic        hdr_ready_o;
   logic [3:0]  hdr_tag_i = '0;
   logic [63:0] hdr_i = '0;
   logic [4:0]  hdr_words_i = '0;
   logic        ret_v_i = 1'b0;
   logic        ret_ready_o;
   logic [3:0]  ret_tag_i = '0;
   logic [3:0]  ret_word_i = '0;
   logic [31:0] ret_data_i = '0;
   logic [63:0] mem_header_o;
   logic [63:0] mem_data_o;
   logic        mem_v_o;
   logic        mem_last_o;
   logic        mem_ready_and_i = 1'b0;

   always #5 clk_i = ~clk_i;

   bp_hb_mem_resp_gen dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .hdr_v_i         (hdr_v_i),
      .hdr_ready_o     (hdr_ready_o),
      .hdr_tag_i       (hdr_tag_i),
      .hdr_i           (hdr_i),
      .hdr_words_i     (hdr_words_i),
      .ret_v_i         (ret_v_i),
      .ret_ready_o     (ret_ready_o),
      .ret_tag_i       (ret_tag_i),
      .ret_word_i      (ret_word_i),
      .ret_data_i      (ret_data_i),
      .mem_header_o    (mem_header_o),
      .mem_data_o      (mem_data_o),
      .mem_v_o         (mem_v_o),
      .mem_last_o      (mem_last_o),
      .mem_ready_and_i (mem_ready_and_i)
   );

   typedef struct {
      int          tag;
      int          words;
      logic [63:0] hdr;
      logic [31:0] base;
      bit          rev;
      int          stall_beat;
      int          nbeats;
      logic [63:0] beat0;
      logic [63:0] beatl;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   logic        exp_valid [16];
   logic [31:0] model_buf [16];
   logic [3:0]  rorder    [16];
   logic [31:0] rdata     [16];
   logic [63:0] got_data  [32];
   logic [63:0] got_hdr   [32];
   logic        got_last  [32];
   vec_t        vecs      [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected beat k: word 2k low, word 2k+1 high, words past the count read as zero.
   function automatic logic [63:0] exp_beat(input int n, input int k);
      logic [31:0] lo;
      logic [31:0] hi;
      lo = '0;
      hi = '0;
      if (2 * k < n) lo = model_buf[4'(2 * k)];
      if (2 * k + 1 < n) hi = model_buf[4'(2 * k + 1)];
      return {hi, lo};
   endfunction

   task automatic send_hdr(input logic [3:0] tag, input logic [4:0] n, input logic [63:0] h);
      int w = 0;
      hdr_v_i = 1'b1; hdr_tag_i = tag; hdr_words_i = n; hdr_i = h;
      #1;
      while (!hdr_ready_o && w < 50) begin @(negedge clk_i); #1; w++; end
      check("hdr_accept", hdr_ready_o, 1'b1);
      @(negedge clk_i);
      hdr_v_i = 1'b0;
      exp_valid[tag] = 1'b1;
   endtask

   task automatic send_ret(input logic [3:0] tag, input logic [3:0] word, input logic [31:0] d);
      int w = 0;
      ret_v_i = 1'b1; ret_tag_i = tag; ret_word_i = word; ret_data_i = d;
      #1;
      while (!ret_ready_o && w < 50) begin @(negedge clk_i); #1; w++; end
      check("ret_accept", ret_ready_o, 1'b1);
      @(negedge clk_i);
      ret_v_i = 1'b0;
   endtask

   task automatic drain(input int stall_beat, input int stall_len, output int nb);
      int          waited = 0;
      int          st = 0;
      int          first_wait = -1;
      bit          done = 1'b0;
      logic [63:0] hold_d;
      logic [63:0] hold_h;
      logic        hold_l;
      nb = 0;
      hold_d = '0; hold_h = '0; hold_l = 1'b0;
      while (!done && waited < 200 && nb < 32) begin
         #1;
         if (mem_v_o) begin
            if (first_wait < 0) first_wait = waited;
            check("ret_ready_stream", ret_ready_o, 1'b0);
            check("hdr_ready_busy", hdr_ready_o, !exp_valid[hdr_tag_i]);
            if (nb == stall_beat && st < stall_len) begin
               mem_ready_and_i = 1'b0;
               if (st == 0) begin
                  hold_d = mem_data_o; hold_h = mem_header_o; hold_l = mem_last_o;
               end else begin
                  check("stall_data", mem_data_o, hold_d);
                  check("stall_hdr", mem_header_o, hold_h);
                  check("stall_last", mem_last_o, hold_l);
               end
               st++;
            end else begin
               mem_ready_and_i = 1'b1;
               got_data[nb] = mem_data_o;
               got_hdr[nb]  = mem_header_o;
               got_last[nb] = mem_last_o;
               nb++;
               if (mem_last_o) done = 1'b1;
            end
         end
         @(negedge clk_i);
         waited++;
      end
      mem_ready_and_i = 1'b0;
      check("stream_done", done, 1'b1);
      check("latency", first_wait, 0);
   endtask

   task automatic verify(input logic [3:0] tag, input int n, input logic [63:0] h, input int nb,
                         input bit conflict);
      int enb = (n == 0) ? 1 : (n + 1) / 2;
      check("beat_count", nb, enb);
      for (int k = 0; k < nb && k < 32; k++) begin
         check("beat_data", got_data[k], exp_beat(n, k));
         check("beat_hdr", got_hdr[k], h);
         check("beat_last", got_last[k], (k == nb - 1));
      end
      exp_valid[tag] = 1'b0;
      hdr_v_i = 1'b0;
      hdr_tag_i = tag;
      #1;
      check("tag_free", hdr_ready_o, 1'b1);
      @(negedge clk_i);
      if (conflict) begin
         #1;
         check("no_write_on_free", hdr_ready_o, 1'b1);
         @(negedge clk_i);
      end
   endtask

   // Uses rorder/rdata as the return sequence; a zero-word response sends one return.
   task automatic run_resp(input logic [3:0] tag, input int n, input logic [63:0] h,
                           input int stall_beat, input int stall_len, input bit conflict,
                           output int nb);
      int nret = (n == 0) ? 1 : n;
      for (int i = 0; i < 16; i++) model_buf[i] = '0;
      send_hdr(tag, 5'(n), h);
      if (conflict) begin
         hdr_v_i = 1'b1; hdr_tag_i = tag; hdr_i = ~h;
         #1;
         check("hdr_conflict", hdr_ready_o, 1'b0);
         @(negedge clk_i);
      end
      for (int i = 0; i < nret; i++) begin
         send_ret(tag, rorder[i], rdata[i]);
         if (n > 0) model_buf[rorder[i]] = rdata[i];
      end
      drain(stall_beat, stall_len, nb);
      verify(tag, n, h, nb, conflict);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nb;
      int n;
      logic [3:0]  t;
      logic [3:0]  tmp;
      logic [63:0] h;

      for (int i = 0; i < 16; i++) exp_valid[i] = 1'b0;

      vecs[0] = '{3, 16, 64'hDEAD_BEEF_0000_0003, 32'h100, 1'b1, -1, 8,
                  64'h00000101_00000100, 64'h0000010F_0000010E};
      vecs[1] = '{1, 3, 64'h1111_2222_3333_0001, 32'hA00, 1'b0, -1, 2,
                  64'h00000A01_00000A00, 64'h00000000_00000A02};
      vecs[2] = '{5, 0, 64'h5555_AAAA_0000_0005, 32'hBEEF, 1'b0, -1, 1,
                  64'h0, 64'h0};
      vecs[3] = '{9, 1, 64'h0909_0909_0909_0909, 32'h55, 1'b0, 0, 1,
                  64'h00000000_00000055, 64'h00000000_00000055};
      vecs[4] = '{15, 5, 64'hF0F0_0000_0000_000F, 32'h200, 1'b1, 1, 3,
                  64'h00000201_00000200, 64'h00000000_00000204};

      // Reset behaviour, asserted from time zero.
      ret_v_i = 1'b1;
      repeat (2) @(negedge clk_i);
      #1;
      check("reset_mem_v", mem_v_o, 1'b0);
      check("reset_mem_last", mem_last_o, 1'b0);
      check("reset_ret_ready", ret_ready_o, 1'b0);
      ret_v_i = 1'b0;
      reset_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         hdr_tag_i = 4'(i);
         #1;
         check("post_reset_hdr_ready", hdr_ready_o, 1'b1);
      end
      @(negedge clk_i);

      // Table-driven responses.
      foreach (vecs[v]) begin
         n = vecs[v].words;
         for (int j = 0; j < 16; j++) begin
            rorder[j] = vecs[v].rev ? 4'(n - 1 - j) : 4'(j);
            rdata[j]  = vecs[v].base + 32'(rorder[j]);
         end
         run_resp(4'(vecs[v].tag), n, vecs[v].hdr, vecs[v].stall_beat, 5, 1'b0, nb);
         check("vec_nbeats", nb, vecs[v].nbeats);
         check("vec_beat0", got_data[0], vecs[v].beat0);
         check("vec_beatl", got_data[nb > 0 ? nb - 1 : 0], vecs[v].beatl);
      end

      // Duplicate offset overwrites and still counts.
      rorder[0] = 4'd0; rdata[0] = 32'h1234_0000;
      rorder[1] = 4'd0; rdata[1] = 32'h5678_0000;
      run_resp(4'd10, 2, 64'hD0D0_0000_0000_000A, -1, 0, 1'b0, nb);
      check("dup_beat", got_data[0], 64'h00000000_56780000);

      // Tags 2 and 4 pending; tag 2 owns the buffer, tag 4 stalls until it streams.
      for (int i = 0; i < 16; i++) model_buf[i] = '0;
      send_hdr(4'd2, 5'd4, 64'h2222_0000_0000_0002);
      send_hdr(4'd4, 5'd2, 64'h4444_0000_0000_0004);
      for (int i = 0; i < 4; i++) begin
         send_ret(4'd2, 4'(i), 32'h2000 + 32'(i));
         model_buf[i] = 32'h2000 + 32'(i);
         if (i < 3) begin
            ret_v_i = 1'b1; ret_tag_i = 4'd4; ret_word_i = 4'(i); ret_data_i = 32'hBAD0 + 32'(i);
            #1;
            check("interleave_stall", ret_ready_o, 1'b0);
            @(negedge clk_i);
            ret_v_i = 1'b0;
         end
      end
      drain(1, 5, nb);
      verify(4'd2, 4, 64'h2222_0000_0000_0002, nb, 1'b0);
      for (int i = 0; i < 16; i++) model_buf[i] = '0;
      for (int i = 0; i < 2; i++) begin
         send_ret(4'd4, 4'(1 - i), 32'h4000 + 32'(1 - i));
         model_buf[1 - i] = 32'h4000 + 32'(1 - i);
      end
      drain(0, 5, nb);
      verify(4'd4, 2, 64'h4444_0000_0000_0004, nb, 1'b0);

      // Header for an already-valid tag is refused until its last beat is consumed.
      rorder[0] = 4'd1; rdata[0] = 32'h7777_0001;
      rorder[1] = 4'd0; rdata[1] = 32'h7777_0000;
      run_resp(4'd7, 2, 64'h7777_0000_0000_0007, -1, 0, 1'b1, nb);

      // Reset mid-COLLECT after 2 of 4 words.
      send_hdr(4'd6, 5'd4, 64'h6666_0000_0000_0006);
      send_ret(4'd6, 4'd0, 32'h6660);
      send_ret(4'd6, 4'd1, 32'h6661);
      reset_i = 1'b1; ret_v_i = 1'b1; ret_tag_i = 4'd6;
      #1;
      check("rst_collect_mem_v", mem_v_o, 1'b0);
      check("rst_collect_ret_ready", ret_ready_o, 1'b0);
      @(negedge clk_i);
      ret_v_i = 1'b0;
      reset_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         exp_valid[i] = 1'b0;
         hdr_tag_i = 4'(i);
         #1;
         check("rst_tags_free", hdr_ready_o, 1'b1);
      end
      @(negedge clk_i);
      for (int j = 0; j < 4; j++) begin rorder[j] = 4'(j); rdata[j] = 32'h6000 + 32'(j); end
      run_resp(4'd6, 4, 64'h6666_1111_0000_0006, -1, 0, 1'b0, nb);

      // Reset mid-STREAM emits no further beats.
      send_hdr(4'd8, 5'd4, 64'h8888_0000_0000_0008);
      for (int j = 0; j < 4; j++) send_ret(4'd8, 4'(j), 32'h8000 + 32'(j));
      #1;
      check("stream_before_reset", mem_v_o, 1'b1);
      reset_i = 1'b1;
      #1;
      check("rst_stream_mem_v", mem_v_o, 1'b0);
      check("rst_stream_mem_last", mem_last_o, 1'b0);
      @(negedge clk_i);
      reset_i = 1'b0;
      for (int i = 0; i < 16; i++) exp_valid[i] = 1'b0;
      @(negedge clk_i);
      #1;
      check("no_beats_after_reset", mem_v_o, 1'b0);
      @(negedge clk_i);

      // Random responses with shuffled offsets and random backpressure.
      for (int r = 0; r < 25; r++) begin
         t = 4'($urandom_range(0, 15));
         ret_v_i = 1'b1; ret_tag_i = t; ret_word_i = 4'($urandom_range(0, 15));
         ret_data_i = $urandom;
         #1;
         check("invalid_tag_stall", ret_ready_o, exp_valid[t]);
         @(negedge clk_i);
         ret_v_i = 1'b0;
         t = 4'($urandom_range(0, 15));
         n = $urandom_range(0, 16);
         h = {$urandom, $urandom};
         for (int j = 0; j < 16; j++) begin rorder[j] = 4'(j); rdata[j] = $urandom; end
         for (int j = n - 1; j > 0; j--) begin
            int k = $urandom_range(0, j);
            tmp = rorder[j]; rorder[j] = rorder[k]; rorder[k] = tmp;
         end
         run_resp(t, n, h, $urandom_range(0, 8), $urandom_range(0, 4), 1'b0, nb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
